// File: rtl/stack_seq_unit.sv
// Stack micro-sequencer for CALL/RET/INT/RTI: multi-word PC push/pop, CCR save/restore, freezes, pc_sel.
// Optional occupancy checking with over/underflow rejection is built when STACK_CHECK_EN is defined.
module stack_seq_unit #(
    parameter int PC_WORDS    = 2,
    parameter int STACK_DEPTH = 1024,
    localparam int SEL_W      = $clog2(PC_WORDS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             call,
    input  logic             ret,
    input  logic             rti,
    input  logic             int_req,
    input  logic             hazard_hold,
    output logic             int_ack,
    output logic             busy,
    output logic             freeze_pc,
    output logic             freeze_cu,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic             stack,
    output logic [SEL_W-1:0] push_sel,
    output logic             pop_pc,
    output logic [SEL_W-1:0] pop_idx,
    output logic             pop_ccr,
    output logic [1:0]       pc_sel,
    output logic             stk_err
);

    typedef enum logic [3:0] {
        IDLE, HOLD, FRZ_PC, FRZ_CU, PUSH, PUSH_CCR,
        POP_CCR, POP, LOAD_CALL, LOAD_INT, LOAD_POP
    } state_t;

    localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(PC_WORDS - 1);
    localparam logic [SEL_W-1:0] CCR_SEL   = SEL_W'(PC_WORDS + 1);

    state_t           state_reg;
    logic [SEL_W-1:0] word_reg;
    logic             int_seq_reg;
    logic             int_pend_reg;
    logic             ok_call, ok_int, ok_ret, ok_rti;

`ifdef STACK_CHECK_EN
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [DEPTH_W-1:0] occ_reg;
    logic               stk_err_reg;

    assign ok_call = (int'(occ_reg) + PC_WORDS) <= STACK_DEPTH;
    assign ok_int  = (int'(occ_reg) + PC_WORDS + 1) <= STACK_DEPTH;
    assign ok_ret  = int'(occ_reg) >= PC_WORDS;
    assign ok_rti  = int'(occ_reg) >= (PC_WORDS + 1);

    // Error is flagged for whichever request the IDLE priority would have dispatched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg     <= '0;
            stk_err_reg <= 1'b0;
        end else begin
            stk_err_reg <= (state_reg == IDLE) &&
                           (rti ? !ok_rti :
                            ret ? !ok_ret :
                            call ? !ok_call :
                            (int_pend_reg && !ok_int));
            if (state_reg == PUSH || state_reg == PUSH_CCR)
                occ_reg <= occ_reg + DEPTH_W'(1);
            else if (state_reg == POP || state_reg == POP_CCR)
                occ_reg <= occ_reg - DEPTH_W'(1);
        end
    end

    assign stk_err = stk_err_reg;
`else
    assign ok_call = 1'b1;
    assign ok_int  = 1'b1;
    assign ok_ret  = 1'b1;
    assign ok_rti  = 1'b1;
    assign stk_err = 1'b0;
`endif

    // Acknowledge is combinational so it coincides with the capture cycle.
    assign int_ack = rst && int_req && !int_pend_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            word_reg     <= '0;
            int_seq_reg  <= 1'b0;
            int_pend_reg <= 1'b0;
        end else begin
            if (!int_pend_reg && int_req)
                int_pend_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    word_reg <= '0;
                    if (rti) begin
                        if (ok_rti) state_reg <= POP_CCR;
                    end else if (ret) begin
                        if (ok_ret) state_reg <= POP;
                    end else if (call) begin
                        if (ok_call) begin
                            state_reg   <= PUSH;
                            int_seq_reg <= 1'b0;
                        end
                    end else if (int_pend_reg) begin
                        if (ok_int) begin
                            state_reg   <= hazard_hold ? HOLD : FRZ_PC;
                            int_seq_reg <= 1'b1;
                        end else begin
                            int_pend_reg <= 1'b0;
                        end
                    end
                end
                HOLD:     if (!hazard_hold) state_reg <= FRZ_PC;
                FRZ_PC:   state_reg <= FRZ_CU;
                FRZ_CU: begin
                    state_reg    <= PUSH;
                    word_reg     <= '0;
                    int_pend_reg <= 1'b0;
                end
                PUSH: begin
                    if (word_reg == LAST_WORD) begin
                        word_reg  <= '0;
                        state_reg <= int_seq_reg ? PUSH_CCR : LOAD_CALL;
                    end else begin
                        word_reg <= word_reg + SEL_W'(1);
                    end
                end
                PUSH_CCR: state_reg <= LOAD_INT;
                POP_CCR:  state_reg <= POP;
                POP: begin
                    if (word_reg == LAST_WORD) begin
                        word_reg  <= '0;
                        state_reg <= LOAD_POP;
                    end else begin
                        word_reg <= word_reg + SEL_W'(1);
                    end
                end
                LOAD_CALL, LOAD_INT, LOAD_POP: state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        freeze_pc = !(state_reg == IDLE || state_reg == HOLD);
        freeze_cu = !(state_reg == IDLE || state_reg == HOLD || state_reg == FRZ_PC);
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        stack     = 1'b0;
        push_sel  = '0;
        pop_pc    = 1'b0;
        pop_idx   = '0;
        pop_ccr   = 1'b0;
        pc_sel    = 2'b00;
        case (state_reg)
            PUSH: begin
                mem_wr   = 1'b1;
                stack    = 1'b1;
                push_sel = word_reg + SEL_W'(1);
            end
            PUSH_CCR: begin
                mem_wr   = 1'b1;
                stack    = 1'b1;
                push_sel = CCR_SEL;
            end
            POP: begin
                mem_rd  = 1'b1;
                stack   = 1'b1;
                pop_pc  = 1'b1;
                pop_idx = LAST_WORD - word_reg;
            end
            POP_CCR: begin
                mem_rd  = 1'b1;
                stack   = 1'b1;
                pop_ccr = 1'b1;
            end
            LOAD_CALL: pc_sel = 2'b11;
            LOAD_INT:  pc_sel = 2'b10;
            LOAD_POP:  pc_sel = 2'b01;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_seq_unit.sv
// Directed bench for stack_seq_unit (PC_WORDS=2): per-cycle output vectors compared against hand-derived constants.
// With STACK_CHECK_EN defined it runs the occupancy/rejection scenarios with STACK_DEPTH=4.
module tb_stack_seq_unit;

`ifdef STACK_CHECK_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       call = 1'b0, ret = 1'b0, rti = 1'b0, int_req = 1'b0, hazard_hold = 1'b0;
    logic       int_ack, busy, freeze_pc, freeze_cu, mem_wr, mem_rd, stack, pop_pc, pop_ccr, stk_err;
    logic [1:0] push_sel, pop_idx, pc_sel;
    logic [15:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    // {ack,busy,fpc,fcu,wr,rd,stack,push_sel[2],pop_pc,pop_idx[2],pop_ccr,pc_sel[2],err}
    localparam logic [15:0] V_IDLE  = 16'h0000;
    localparam logic [15:0] V_ACK   = 16'h8000;
    localparam logic [15:0] V_ERR   = 16'h0001;
    localparam logic [15:0] V_HOLD  = 16'h4000;
    localparam logic [15:0] V_FPC   = 16'h6000;
    localparam logic [15:0] V_FCU   = 16'h7000;
    localparam logic [15:0] V_PSH1  = 16'h7A80;
    localparam logic [15:0] V_PSH2  = 16'h7B00;
    localparam logic [15:0] V_PCCR  = 16'h7B80;
    localparam logic [15:0] V_LDC   = 16'h7006;
    localparam logic [15:0] V_LDI   = 16'h7004;
    localparam logic [15:0] V_LDP   = 16'h7002;
    localparam logic [15:0] V_POPC  = 16'h7608;
    localparam logic [15:0] V_POP1  = 16'h7650;
    localparam logic [15:0] V_POP0  = 16'h7640;

    always #5 clk = ~clk;

    stack_seq_unit #(.PC_WORDS(2), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret), .rti(rti),
        .int_req(int_req), .hazard_hold(hazard_hold),
        .int_ack(int_ack), .busy(busy), .freeze_pc(freeze_pc), .freeze_cu(freeze_cu),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .stack(stack), .push_sel(push_sel),
        .pop_pc(pop_pc), .pop_idx(pop_idx), .pop_ccr(pop_ccr), .pc_sel(pc_sel),
        .stk_err(stk_err)
    );

    assign obs = {int_ack, busy, freeze_pc, freeze_cu, mem_wr, mem_rd, stack,
                  push_sel, pop_pc, pop_idx, pop_ccr, pc_sel, stk_err};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then sample the outputs 1 ns later.
    task automatic cyc(input string tag, input logic c, input logic r, input logic ri,
                       input logic ir, input logic hz, input logic [15:0] exp);
        @(negedge clk);
        call = c; ret = r; rti = ri; int_req = ir; hazard_hold = hz;
        #1;
        check(tag, obs, exp);
    endtask

    initial begin
        int_req = 1'b1;
        #3;
        check("reset outputs zero", obs, V_IDLE);
        @(negedge clk);
        int_req = 1'b0;
        rst = 1'b1;
        #1;
        check("after release idle", obs, V_IDLE);

`ifdef STACK_CHECK_EN
        cyc("t6 ret empty",      0, 1, 0, 0, 0, V_IDLE);
        cyc("t6 ret err",        0, 0, 0, 0, 0, V_ERR);
        cyc("t6 err clears",     0, 0, 0, 0, 0, V_IDLE);
        for (int k = 0; k < 2; k++) begin
            cyc("t6 call",       1, 0, 0, 0, 0, V_IDLE);
            cyc("t6 push1",      0, 0, 0, 0, 0, V_PSH1);
            cyc("t6 push2",      0, 0, 0, 0, 0, V_PSH2);
            cyc("t6 load",       0, 0, 0, 0, 0, V_LDC);
        end
        cyc("t6 call3 full",     1, 0, 0, 0, 0, V_IDLE);
        cyc("t6 call3 err",      0, 0, 0, 0, 0, V_ERR);
        cyc("t6 no wr",          0, 0, 0, 0, 0, V_IDLE);
        cyc("t6 int ack",        0, 0, 0, 1, 0, V_ACK);
        cyc("t6 int rejected",   0, 0, 0, 0, 0, V_IDLE);
        cyc("t6 int err reack",  0, 0, 0, 1, 0, V_ERR | V_ACK);
        cyc("t6 int rej again",  0, 0, 0, 0, 0, V_IDLE);
        cyc("t6 int err2",       0, 0, 0, 0, 0, V_ERR);
        cyc("t6 rti ok",         0, 0, 1, 0, 0, V_IDLE);
        cyc("t6 pop ccr",        0, 0, 0, 0, 0, V_POPC);
        cyc("t6 pop1",           0, 0, 0, 0, 0, V_POP1);
        cyc("t6 pop0",           0, 0, 0, 0, 0, V_POP0);
        cyc("t6 load pop",       0, 0, 0, 0, 0, V_LDP);
        cyc("t6 ret under",      0, 1, 0, 0, 0, V_IDLE);
        cyc("t6 ret err",        0, 0, 0, 0, 0, V_ERR);
`else
        // CALL, with a RET during the push run that must be ignored
        cyc("t1 call",           1, 0, 0, 0, 0, V_IDLE);
        cyc("t1 push1",          0, 1, 0, 0, 0, V_PSH1);
        cyc("t1 push2",          0, 0, 0, 0, 0, V_PSH2);
        cyc("t1 load call",      0, 0, 0, 0, 0, V_LDC);
        cyc("t1 idle",           0, 0, 0, 0, 0, V_IDLE);

        // INT held off by hazard_hold for three HOLD cycles
        cyc("t2 int ack",        0, 0, 0, 1, 1, V_ACK);
        cyc("t2 idle pend",      0, 0, 0, 1, 1, V_IDLE);
        cyc("t2 hold a",         0, 0, 0, 1, 1, V_HOLD);
        cyc("t2 hold b",         0, 0, 0, 0, 1, V_HOLD);
        cyc("t2 hold c",         0, 0, 0, 0, 0, V_HOLD);
        cyc("t2 frz pc",         0, 0, 0, 0, 0, V_FPC);
        cyc("t2 frz cu",         0, 0, 0, 0, 0, V_FCU);
        cyc("t2 push1",          0, 0, 0, 0, 0, V_PSH1);
        cyc("t2 push2",          0, 0, 0, 0, 0, V_PSH2);
        cyc("t2 push ccr",       0, 0, 0, 0, 0, V_PCCR);
        cyc("t2 load int",       0, 0, 0, 0, 0, V_LDI);
        cyc("t2 idle",           0, 0, 0, 0, 0, V_IDLE);

        // RTI wins over simultaneous RET and CALL
        cyc("t3 rti+ret+call",   1, 1, 1, 0, 0, V_IDLE);
        cyc("t3 pop ccr",        0, 0, 0, 0, 0, V_POPC);
        cyc("t3 pop1",           0, 0, 0, 0, 0, V_POP1);
        cyc("t3 pop0",           0, 0, 0, 0, 0, V_POP0);
        cyc("t3 load pop",       0, 0, 0, 0, 0, V_LDP);
        cyc("t3 idle",           0, 0, 0, 0, 0, V_IDLE);

        // RET beats CALL
        cyc("t3 ret+call",       1, 1, 0, 0, 0, V_IDLE);
        cyc("t3 ret pop1",       0, 0, 0, 0, 0, V_POP1);
        cyc("t3 ret pop0",       0, 0, 0, 0, 0, V_POP0);
        cyc("t3 ret load",       0, 0, 0, 0, 0, V_LDP);

        // CALL beats a same-cycle interrupt; INT follows from IDLE
        cyc("t4 call+int",       1, 0, 0, 1, 0, V_ACK);
        cyc("t4 push1",          0, 0, 0, 1, 0, V_PSH1);
        cyc("t4 push2",          0, 0, 0, 0, 0, V_PSH2);
        cyc("t4 load call",      0, 0, 0, 0, 0, V_LDC);
        cyc("t4 idle dispatch",  0, 0, 0, 0, 0, V_IDLE);
        cyc("t4 frz pc",         0, 0, 0, 0, 0, V_FPC);
        cyc("t4 frz cu",         0, 0, 0, 0, 0, V_FCU);
        cyc("t4 push1 int",      0, 0, 0, 0, 0, V_PSH1);
        cyc("t4 push2 int",      0, 0, 0, 0, 0, V_PSH2);
        cyc("t4 push ccr",       0, 0, 0, 0, 0, V_PCCR);
        cyc("t4 load int",       0, 0, 0, 0, 0, V_LDI);
        cyc("t4 idle",           0, 0, 0, 0, 0, V_IDLE);

        // Reset mid-sequence with an interrupt pending
        cyc("t5 call",           1, 0, 0, 0, 0, V_IDLE);
        cyc("t5 push1 ack",      0, 0, 0, 1, 0, V_PSH1 | V_ACK);
        cyc("t5 push2",          0, 0, 0, 0, 0, V_PSH2);
        rst = 1'b0;
        #1;
        check("t5 async reset", obs, V_IDLE);
        @(negedge clk);
        int_req = 1'b1;
        #1;
        check("t5 held reset", obs, V_IDLE);
        @(negedge clk);
        int_req = 1'b0;
        rst = 1'b1;
        #1;
        check("t5 released", obs, V_IDLE);
        cyc("t5 pend cleared",   0, 0, 0, 1, 0, V_ACK);
        cyc("t5 idle dispatch",  0, 0, 0, 0, 0, V_IDLE);
        cyc("t5 frz pc",         0, 0, 0, 0, 0, V_FPC);
        cyc("t5 frz cu",         0, 0, 0, 0, 0, V_FCU);
        cyc("t5 push1",          0, 0, 0, 0, 0, V_PSH1);
        cyc("t5 push2",          0, 0, 0, 0, 0, V_PSH2);
        cyc("t5 push ccr",       0, 0, 0, 0, 0, V_PCCR);
        cyc("t5 load int",       0, 0, 0, 0, 0, V_LDI);
        cyc("t5 idle",           0, 0, 0, 0, 0, V_IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
